// File: rtl/mandelbrot_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_sched_if
// Description : Pixel-in, datapath and retire-out signal bundle for the
//               Mandelbrot pass scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
interface mandelbrot_sched_if #(
  parameter int DW = 16,
  parameter int TW = 16,
  parameter int IW = 8
);
  // New pixel offer
  logic                 i_valid;
  logic                 i_ready;
  logic signed [DW-1:0] i_cx;
  logic signed [DW-1:0] i_cy;
  logic [TW-1:0]        i_tag;

  // Datapath issue side
  logic signed [DW-1:0] dp_x;
  logic signed [DW-1:0] dp_y;
  logic signed [DW-1:0] dp_cx;
  logic signed [DW-1:0] dp_cy;

  // Datapath return side, LAT cycles behind issue
  logic signed [DW-1:0] dp_x_r;
  logic signed [DW-1:0] dp_y_r;
  logic signed [DW-1:0] dp_cx_r;
  logic signed [DW-1:0] dp_cy_r;
  logic                 dp_esc;

  // Retired pixel
  logic                 o_valid;
  logic                 o_ready;
  logic [TW-1:0]        o_tag;
  logic [IW-1:0]        o_iter;
  logic                 o_busy;

  // Scheduler side
  modport slave (
    input  i_valid, i_cx, i_cy, i_tag,
    input  dp_x_r, dp_y_r, dp_cx_r, dp_cy_r, dp_esc,
    input  o_ready,
    output i_ready,
    output dp_x, dp_y, dp_cx, dp_cy,
    output o_valid, o_tag, o_iter, o_busy
  );

  // Environment side: pixel source, datapath and colour stage
  modport master (
    output i_valid, i_cx, i_cy, i_tag,
    output dp_x_r, dp_y_r, dp_cx_r, dp_cy_r, dp_esc,
    output o_ready,
    input  i_ready,
    input  dp_x, dp_y, dp_cx, dp_cy,
    input  o_valid, o_tag, o_iter, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/mandelbrot_sched.sv
`default_nettype none
// ============================================================================
// Module      : mandelbrot_sched
// Description : Time-multiplexes one fixed-latency Mandelbrot iteration
//               pipeline across up to LAT+1 pixels. Returning slots are
//               recirculated, retired or freed for a new pixel each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mandelbrot_sched #(
  parameter int DW       = 16,
  parameter int TW       = 16,
  parameter int IW       = 8,
  parameter int MAX_ITER = 255,
  parameter int LAT      = 3
) (
  input  wire logic        i_clk,
  input  wire logic        i_rstn,
  mandelbrot_sched_if.slave bus
);

  localparam logic [IW-1:0] c_max_iter = IW'(MAX_ITER);
  localparam logic [IW-1:0] c_iter_one = IW'(1);

  // Issue register: datapath operands plus the slot bookkeeping
  logic signed [DW-1:0] r_dp_x;
  logic signed [DW-1:0] r_dp_y;
  logic signed [DW-1:0] r_dp_cx;
  logic signed [DW-1:0] r_dp_cy;
  logic                 r_iss_valid;
  logic                 r_iss_done;
  logic [IW-1:0]        r_iss_iter;
  logic [TW-1:0]        r_iss_tag;

  // Shadow of the slot bookkeeping travelling alongside the datapath
  logic [LAT-1:0]       r_sh_valid;
  logic [LAT-1:0]       r_sh_done;
  logic [IW-1:0]        r_sh_iter [LAT];
  logic [TW-1:0]        r_sh_tag  [LAT];

  // Retire register
  logic                 r_o_valid;
  logic [TW-1:0]        r_o_tag;
  logic [IW-1:0]        r_o_iter;

  // Returning slot and its evaluation
  logic                 w_tail_valid;
  logic                 w_tail_done;
  logic [IW-1:0]        w_tail_iter;
  logic [TW-1:0]        w_tail_tag;
  logic [IW-1:0]        w_iter_inc;
  logic                 w_finish;
  logic [IW-1:0]        w_res_iter;
  logic                 w_out_load_ok;
  logic                 w_retire;
  logic                 w_recirc;
  logic                 w_accept;

  assign w_tail_valid = r_sh_valid[LAT-1];
  assign w_tail_done  = r_sh_done[LAT-1];
  assign w_tail_iter  = r_sh_iter[LAT-1];
  assign w_tail_tag   = r_sh_tag[LAT-1];

  // Only pixels still iterating can reach MAX_ITER here, so the increment never wraps
  assign w_iter_inc   = w_tail_iter + c_iter_one;

  // Classify the returning slot: finished (with result count) or still iterating
  always_comb begin
    w_finish   = 1'b0;
    w_res_iter = w_tail_iter;
    if (w_tail_valid) begin
      if (w_tail_done || bus.dp_esc) begin
        w_finish = 1'b1;
      end else begin
        w_res_iter = w_iter_inc;
        w_finish   = (w_iter_inc == c_max_iter);
      end
    end
  end

  // A finished slot retires only when the output register can take it;
  // otherwise it keeps circulating so in-flight pixels are never dropped.
  assign w_out_load_ok = !r_o_valid || bus.o_ready;
  assign w_retire      = w_finish && w_out_load_ok;
  assign w_recirc      = w_tail_valid && !w_retire;
  assign w_accept      = bus.i_valid && bus.i_ready;

  assign bus.i_ready = i_rstn && !w_recirc;
  assign bus.dp_x    = r_dp_x;
  assign bus.dp_y    = r_dp_y;
  assign bus.dp_cx   = r_dp_cx;
  assign bus.dp_cy   = r_dp_cy;
  assign bus.o_valid = r_o_valid;
  assign bus.o_tag   = r_o_tag;
  assign bus.o_iter  = r_o_iter;
  assign bus.o_busy  = r_iss_valid || (|r_sh_valid) || r_o_valid;

  // Issue register: recirculation first, then injection, else an empty slot
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_dp_x      <= '0;
      r_dp_y      <= '0;
      r_dp_cx     <= '0;
      r_dp_cy     <= '0;
      r_iss_valid <= 1'b0;
      r_iss_done  <= 1'b0;
      r_iss_iter  <= '0;
      r_iss_tag   <= '0;
    end else if (w_recirc) begin
      r_dp_x      <= bus.dp_x_r;
      r_dp_y      <= bus.dp_y_r;
      r_dp_cx     <= bus.dp_cx_r;
      r_dp_cy     <= bus.dp_cy_r;
      r_iss_valid <= 1'b1;
      r_iss_done  <= w_finish;
      r_iss_iter  <= w_res_iter;
      r_iss_tag   <= w_tail_tag;
    end else if (w_accept) begin
      r_dp_x      <= '0;
      r_dp_y      <= '0;
      r_dp_cx     <= bus.i_cx;
      r_dp_cy     <= bus.i_cy;
      r_iss_valid <= 1'b1;
      r_iss_done  <= 1'b0;
      r_iss_iter  <= '0;
      r_iss_tag   <= bus.i_tag;
    end else begin
      r_iss_valid <= 1'b0;
    end
  end

  // Shadow shift register, aligned so its tail meets the datapath results
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_sh_valid <= '0;
      r_sh_done  <= '0;
      for (int i = 0; i < LAT; i++) begin
        r_sh_iter[i] <= '0;
        r_sh_tag[i]  <= '0;
      end
    end else begin
      r_sh_valid[0] <= r_iss_valid;
      r_sh_done[0]  <= r_iss_done;
      r_sh_iter[0]  <= r_iss_iter;
      r_sh_tag[0]   <= r_iss_tag;
      for (int i = 1; i < LAT; i++) begin
        r_sh_valid[i] <= r_sh_valid[i-1];
        r_sh_done[i]  <= r_sh_done[i-1];
        r_sh_iter[i]  <= r_sh_iter[i-1];
        r_sh_tag[i]   <= r_sh_tag[i-1];
      end
    end
  end

  // Output register: load on retire, drop when the consumer takes it
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_o_valid <= 1'b0;
      r_o_tag   <= '0;
      r_o_iter  <= '0;
    end else if (w_retire) begin
      r_o_valid <= 1'b1;
      r_o_tag   <= w_tail_tag;
      r_o_iter  <= w_res_iter;
    end else if (bus.o_ready) begin
      r_o_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_mandelbrot_sched
// Description : Directed self-checking bench for mandelbrot_sched with a
//               Q4.12 three-stage Mandelbrot datapath model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mandelbrot_sched;

  localparam int DW       = 16;
  localparam int TW       = 16;
  localparam int IW       = 8;
  localparam int MAX_ITER = 4;
  localparam int LAT      = 3;

  localparam logic signed [15:0] C_2P5   = 16'sd10240;  // 2.5 in Q4.12
  localparam logic signed [15:0] C_SMALL = 16'sd256;    // 1/16 in Q4.12

  logic clk;
  logic rstn;
  int   n_checks = 0;
  int   n_fail   = 0;

  mandelbrot_sched_if #(.DW(DW), .TW(TW), .IW(IW)) bus ();

  mandelbrot_sched #(
    .DW(DW), .TW(TW), .IW(IW), .MAX_ITER(MAX_ITER), .LAT(LAT)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath model: z' = z^2 + c, escape when |z_in|^2 > 4
  function automatic logic signed [15:0] mand_x(input logic signed [15:0] x, y, cx);
    logic signed [31:0] a, b;
    a = 32'(x) * 32'(x);
    b = 32'(y) * 32'(y);
    return 16'((a - b) >>> 12) + cx;
  endfunction

  function automatic logic signed [15:0] mand_y(input logic signed [15:0] x, y, cy);
    logic signed [31:0] p;
    p = 32'(x) * 32'(y);
    return 16'(p >>> 11) + cy;
  endfunction

  function automatic logic mand_esc(input logic signed [15:0] x, y);
    logic signed [31:0] a, b;
    a = 32'(x) * 32'(x);
    b = 32'(y) * 32'(y);
    return (a + b) > 32'sd67108864;
  endfunction

  logic signed [15:0] p_x [3];
  logic signed [15:0] p_y [3];
  logic signed [15:0] p_cx[3];
  logic signed [15:0] p_cy[3];
  logic               p_esc[3];

  // Three-cycle datapath pipeline
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < 3; i++) begin
        p_x[i] <= '0; p_y[i] <= '0; p_cx[i] <= '0; p_cy[i] <= '0; p_esc[i] <= 1'b0;
      end
    end else begin
      p_x[0]   <= mand_x(bus.dp_x, bus.dp_y, bus.dp_cx);
      p_y[0]   <= mand_y(bus.dp_x, bus.dp_y, bus.dp_cy);
      p_cx[0]  <= bus.dp_cx;
      p_cy[0]  <= bus.dp_cy;
      p_esc[0] <= mand_esc(bus.dp_x, bus.dp_y);
      for (int i = 1; i < 3; i++) begin
        p_x[i] <= p_x[i-1]; p_y[i] <= p_y[i-1]; p_cx[i] <= p_cx[i-1];
        p_cy[i] <= p_cy[i-1]; p_esc[i] <= p_esc[i-1];
      end
    end
  end

  assign bus.dp_x_r  = p_x[2];
  assign bus.dp_y_r  = p_y[2];
  assign bus.dp_cx_r = p_cx[2];
  assign bus.dp_cy_r = p_cy[2];
  assign bus.dp_esc  = p_esc[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int bad;
    int seen;

    // ---------------- reset ----------------
    rstn        = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_cx    = C_2P5;
    bus.i_cy    = '0;
    bus.i_tag   = 16'h1234;
    bus.o_ready = 1'b1;
    tick(3);
    check("rst_i_ready", 32'(bus.i_ready), 0);
    check("rst_o_valid", 32'(bus.o_valid), 0);
    check("rst_o_busy",  32'(bus.o_busy),  0);
    check("rst_o_tag",   32'(bus.o_tag),   0);
    check("rst_o_iter",  32'(bus.o_iter),  0);
    check("rst_dp_cx",   32'(bus.dp_cx),   0);
    bus.i_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("rel_i_ready", 32'(bus.i_ready), 1);
    check("rel_o_busy",  32'(bus.o_busy),  0);

    // ---------------- escape after one iteration ----------------
    bus.i_valid = 1'b1;
    bus.i_cx    = C_2P5;
    bus.i_cy    = '0;
    bus.i_tag   = 16'h0005;
    tick(1);                       // edge 0: accepted
    bus.i_valid = 1'b0;
    check("esc_dp_cx",  32'(bus.dp_cx),  32'(C_2P5));
    check("esc_dp_x0",  32'(bus.dp_x),   0);
    check("esc_busy",   32'(bus.o_busy), 1);
    tick(4);                       // edge 4: pass 1 recirculated with z = c
    check("esc_dp_x1",  32'(bus.dp_x),   32'(C_2P5));
    tick(3);                       // edge 7
    check("esc_early",  32'(bus.o_valid), 0);
    tick(1);                       // edge 8
    check("esc_valid",  32'(bus.o_valid), 1);
    check("esc_tag",    32'(bus.o_tag),   32'h0005);
    check("esc_iter",   32'(bus.o_iter),  1);
    tick(1);
    check("esc_drain",  32'(bus.o_valid), 0);
    check("esc_idle",   32'(bus.o_busy),  0);

    // ---------------- max iteration ----------------
    bus.i_valid = 1'b1;
    bus.i_cx    = '0;
    bus.i_cy    = '0;
    bus.i_tag   = 16'h00A0;
    tick(1);                       // edge 0
    bus.i_valid = 1'b0;
    tick(15);                      // edge 15
    check("max_early",  32'(bus.o_valid), 0);
    tick(1);                       // edge 16
    check("max_valid",  32'(bus.o_valid), 1);
    check("max_tag",    32'(bus.o_tag),   32'h00A0);
    check("max_iter",   32'(bus.o_iter),  MAX_ITER);
    tick(1);

    // ---------------- fill the ring ----------------
    bus.i_valid = 1'b1;
    bus.i_cx    = '0;
    bus.i_cy    = '0;
    for (int i = 0; i < 4; i++) begin
      bus.i_tag = 16'(i);
      check("fill_ready", 32'(bus.i_ready), 1);
      tick(1);                     // edges 0..3
    end
    bus.i_valid = 1'b0;
    bad = 0;
    for (int k = 3; k <= 14; k++) begin
      if (bus.i_ready !== 1'b0) bad++;
      if (k < 14) tick(1);
    end
    check("fill_ready_low", 32'(bad), 0);
    tick(1);                       // edge 15: pixel 0 retiring this cycle
    check("fill_ready_ret", 32'(bus.i_ready), 1);
    tick(1);                       // edge 16
    for (int i = 0; i < 4; i++) begin
      check("fill_valid", 32'(bus.o_valid), 1);
      check("fill_tag",   32'(bus.o_tag),   32'(i));
      check("fill_iter",  32'(bus.o_iter),  MAX_ITER);
      tick(1);
    end
    check("fill_drain", 32'(bus.o_valid), 0);

    // ---------------- backpressure ----------------
    bus.o_ready = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_cx    = C_2P5;
    bus.i_cy    = '0;
    bus.i_tag   = 16'h000A;
    tick(1);                       // edge 0
    bus.i_tag   = 16'h000B;
    tick(1);                       // edge 1
    bus.i_valid = 1'b0;
    tick(6);                       // edge 7
    check("bp_early",  32'(bus.o_valid), 0);
    tick(1);                       // edge 8
    check("bp_valid",  32'(bus.o_valid), 1);
    check("bp_tag_a",  32'(bus.o_tag),   32'h000A);
    check("bp_iter_a", 32'(bus.o_iter),  1);
    check("bp_ready",  32'(bus.i_ready), 0);   // B returns finished but blocked
    tick(2);                       // edge 10
    check("bp_hold",   32'(bus.o_tag),   32'h000A);
    check("bp_busy",   32'(bus.o_busy),  1);
    bus.o_ready = 1'b1;
    tick(1);                       // edge 11: A taken
    check("bp_taken",  32'(bus.o_valid), 0);
    tick(1);                       // edge 12: B's slot returning now
    check("bp_ready2", 32'(bus.i_ready), 1);
    tick(1);                       // edge 13
    check("bp_valid_b", 32'(bus.o_valid), 1);
    check("bp_tag_b",   32'(bus.o_tag),   32'h000B);
    check("bp_iter_b",  32'(bus.o_iter),  1);
    tick(1);
    check("bp_idle",    32'(bus.o_busy),  0);

    // ---------------- reset mid-run ----------------
    bus.i_valid = 1'b1;
    bus.i_cx    = C_SMALL;
    bus.i_cy    = '0;
    for (int i = 1; i <= 3; i++) begin
      bus.i_tag = 16'(i);
      tick(1);
    end
    bus.i_valid = 1'b0;
    tick(3);
    check("mid_busy_pre", 32'(bus.o_busy), 1);
    rstn = 1'b0;
    #1;
    check("mid_busy_rst", 32'(bus.o_busy),  0);
    check("mid_rdy_rst",  32'(bus.i_ready), 0);
    check("mid_dp_cx",    32'(bus.dp_cx),   0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    #1;
    check("mid_rdy_rel",  32'(bus.i_ready), 1);
    check("mid_busy_rel", 32'(bus.o_busy),  0);
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick(1);
      if (bus.o_valid !== 1'b0) seen++;
    end
    check("mid_no_stale", 32'(seen), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
